// File: rtl/dmem_pkg.sv
// Shared types and helpers for the RV32 data memory controller: access-size
// encodings, controller states, byte-strobe generation, store-data lane
// replication and load extraction/extension.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_IDLE = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Byte-lane write enables for an access of the given size at the given lane.
    // The lane is expected to be already aligned for halves and words.
    function automatic logic [3:0] byte_strobe(input size_e size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate right-aligned store data onto every lane it could target, so
    // the strobes alone pick which bytes land in memory.
    function automatic logic [31:0] store_align(input size_e size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // Pick the addressed byte/half out of a memory word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input size_e size,
                                                 input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
            SZ_WORD: return word;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus of the data memory. Both channels use valid/ready:
// a transfer happens on a rising clock edge where valid and ready are both
// high; the sender holds its payload stable while valid is high and ready low.
// init_done is a plain status signal travelling alongside.
interface dmem_if #(
    parameter int ADDR_W = 32
) ();
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    size_e             req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              init_done;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );
endinterface

// File: rtl/dmem_bank.sv
// DEPTH x 32 single-port synchronous RAM with per-byte write enables and a
// registered read port. The read register only updates when re is high, so
// the last read result is held for as long as the controller needs it.
module dmem_bank #(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr,
    input  logic [3:0]       we,
    input  logic [31:0]      wdata,
    input  logic             re,
    output logic [31:0]      rdata
);
    logic [31:0] mem [DEPTH];

    // Byte-masked write and enabled registered read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/dmem_ctrl.sv
// RV32 data memory controller: post-reset clearing sweep, then one
// load/store per request with a one-cycle response latency and a response
// held until consumed. Owns the FSM, sweep counter and address decode;
// storage lives in dmem_bank.
// Build option: define DMEM_MISALIGN_ERR_EN to fault misaligned accesses;
// otherwise they are aligned down and complete normally.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          DEPTH      = 256,
    parameter int          ADDR_W     = 32,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic   clk,
    input  logic   rst_n,
    dmem_if.slave  bus,
    output state_e fsm_state
);
    localparam int               IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(DEPTH - 1);

    state_e            state;
    logic [IDX_W-1:0]  cnt;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              init_done_q;

    // Captured at the handshake so the response can be formed from the bank output.
    logic              rd_load;
    size_e             rd_size;
    logic [1:0]        rd_lane;
    logic              rd_uns;

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic [1:0]        eff_lane;
    logic              acc_err;
    logic              hs;

    logic [IDX_W-1:0]  bank_addr;
    logic [3:0]        bank_we;
    logic [31:0]       bank_wdata;
    logic              bank_re;
    logic [31:0]       bank_rdata;

    // Decode the incoming request: range, size and alignment checks.
    always_comb begin
        word_idx = bus.req_addr >> 2;
        lane     = bus.req_addr[1:0];
        hs       = bus.req_valid && req_ready_q;
`ifdef DMEM_MISALIGN_ERR_EN
        eff_lane = lane;
        acc_err  = (word_idx >= ADDR_W'(DEPTH)) || (bus.req_size == SZ_ILLEGAL)
                || ((bus.req_size == SZ_HALF) && lane[0])
                || ((bus.req_size == SZ_WORD) && (lane != 2'b00));
`else
        acc_err  = (word_idx >= ADDR_W'(DEPTH)) || (bus.req_size == SZ_ILLEGAL);
        case (bus.req_size)
            SZ_HALF: eff_lane = {lane[1], 1'b0};
            SZ_WORD: eff_lane = 2'b00;
            default: eff_lane = lane;
        endcase
`endif
    end

    // Steer the single RAM port between the clearing sweep and requests.
    always_comb begin
        if (state == ST_INIT) begin
            bank_addr  = cnt;
            bank_we    = 4'b1111;
            bank_wdata = INIT_VALUE;
            bank_re    = 1'b0;
        end else begin
            bank_addr  = word_idx[IDX_W-1:0];
            bank_we    = (hs && bus.req_we && !acc_err) ? byte_strobe(bus.req_size, eff_lane) : 4'b0000;
            bank_wdata = store_align(bus.req_size, bus.req_wdata);
            bank_re    = hs && !bus.req_we && !acc_err;
        end
    end

    dmem_bank #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk   (clk),
        .addr  (bank_addr),
        .we    (bank_we),
        .wdata (bank_wdata),
        .re    (bank_re),
        .rdata (bank_rdata)
    );

    // Controller FSM: sweep, accept one request, hold its response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            cnt         <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            init_done_q <= 1'b0;
            rd_load     <= 1'b0;
            rd_size     <= SZ_BYTE;
            rd_lane     <= 2'b00;
            rd_uns      <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state       <= ST_IDLE;
                        req_ready_q <= 1'b1;
                        init_done_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (hs) begin
                        state       <= ST_RESP;
                        req_ready_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= acc_err;
                        rd_load     <= !bus.req_we && !acc_err;
                        rd_size     <= bus.req_size;
                        rd_lane     <= eff_lane;
                        rd_uns      <= bus.req_unsigned;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= ST_IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rd_load     <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Load data is extended from the held bank read; stores and faults give 0.
    assign bus.rsp_rdata = rd_load ? load_extract(bank_rdata, rd_size, rd_lane, rd_uns) : 32'h0;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.init_done = init_done_q;
    assign fsm_state     = state;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus randomized traffic checked
// against a byte-array reference memory.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int          DEPTH      = 256;
    localparam int          ADDR_W     = 32;
    localparam logic [31:0] INIT_VALUE = 32'h0000_0000;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_e fsm_state;

    dmem_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_ctrl #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .INIT_VALUE (INIT_VALUE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // ---------------- reference model ----------------
    logic [7:0] ref_b [4*DEPTH];

    function automatic void ref_clear();
        logic [31:0] iv;
        iv = INIT_VALUE;
        for (int i = 0; i < 4*DEPTH; i++) ref_b[i] = iv[8*(i%4) +: 8];
    endfunction

    function automatic void ref_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                       input logic uns, input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err);
        int nb;
        int base;
        int off;
        logic [31:0] v;
        rdata = 32'h0;
        err   = 1'b0;
        if (size == 2'b11 || (addr >> 2) >= DEPTH) begin
            err = 1'b1;
            return;
        end
        nb   = 1 << size;
        off  = int'(addr % nb);
        base = int'(addr) - off;
`ifdef DMEM_MISALIGN_ERR_EN
        if (off != 0) begin
            err = 1'b1;
            return;
        end
`endif
        if (we) begin
            for (int i = 0; i < nb; i++) ref_b[base+i] = wdata[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_b[base+i];
            if (!uns && nb < 4 && v[8*nb-1]) begin
                for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
            end
            rdata = v;
        end
    endfunction

    // ---------------- driver ----------------
    task automatic idle_bus();
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = '0;
        bus.req_size     = SZ_WORD;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = '0;
        bus.rsp_ready    = 1'b0;
    endtask

    // One full transaction; called at a negedge, returns at a negedge with the
    // controller back in IDLE. Expected values come from the reference model.
    task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        output logic vld, output logic [31:0] rdata, output logic err,
                        output logic [31:0] exp_rdata, output logic exp_err);
        int n;
        n = 0;
        vld = 1'b0; rdata = 32'h0; err = 1'b0; exp_rdata = 32'h0; exp_err = 1'b0;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_ready !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL req_ready_timeout got %b want 1 after %0d cycles", bus.req_ready, n);
            return;
        end
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_size     = size_e'(size);
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
        @(posedge clk);
        ref_access(we, addr, size, uns, wdata, exp_rdata, exp_err);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        @(negedge clk);
        vld   = bus.rsp_valid;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    // Release reset just after a rising edge and count the cycles spent sweeping.
    task automatic release_and_count(input string tag);
        int  n;
        bit  early_done;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        early_done = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 2000) begin
            if (bus.init_done !== 1'b0) early_done = 1;
            n++;
            @(negedge clk);
        end
        compared++;
        if (n != DEPTH) begin
            mismatched++;
            $display("FAIL %s_sweep_cycles got %0d want %0d", tag, n, DEPTH);
        end
        compared++;
        if (early_done) begin
            mismatched++;
            $display("FAIL %s_init_done_early got 1 want 0 during sweep", tag);
        end
        compared++;
        if (bus.init_done !== 1'b1 || fsm_state !== ST_IDLE) begin
            mismatched++;
            $display("FAIL %s_idle_entry got init_done=%b state=%0d want 1/%0d",
                     tag, bus.init_done, fsm_state, ST_IDLE);
        end
        ref_clear();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_bus();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 ||
            bus.rsp_err !== 1'b0 || bus.init_done !== 1'b0 || fsm_state !== ST_INIT) begin
            mismatched++;
            $display("FAIL reset_values got rdy=%b vld=%b rdata=%h err=%b done=%b st=%0d want 0/0/0/0/0/%0d",
                     bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.init_done,
                     fsm_state, ST_INIT);
        end
        release_and_count("reset");
    endtask

    task automatic test_top_word();
        logic vld, err, eerr;
        logic [31:0] rd, erd;
        send(1'b0, 32'h3FC, 2'b10, 1'b0, 32'h0, vld, rd, err, erd, eerr);
        compared++;
        if (vld !== 1'b1 || rd !== 32'h0000_0000 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL top_word_load got vld=%b rdata=%h err=%b want 1/00000000/0", vld, rd, err);
        end
    endtask

    task automatic test_extend();
        logic vld, err, eerr;
        logic [31:0] rd, erd;
        send(1'b1, 32'h10, 2'b10, 1'b0, 32'h8badf00d, vld, rd, err, erd, eerr);
        compared++;
        if (vld !== 1'b1 || rd !== 32'h0 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL store_rsp got vld=%b rdata=%h err=%b want 1/00000000/0", vld, rd, err);
        end
        send(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, vld, rd, err, erd, eerr);
        compared++;
        if (rd !== 32'hFFFF_FF8B || err !== 1'b0) begin
            mismatched++;
            $display("FAIL lb_signed got %h err=%b want ffffff8b/0", rd, err);
        end
        send(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, vld, rd, err, erd, eerr);
        compared++;
        if (rd !== 32'h0000_008B || err !== 1'b0) begin
            mismatched++;
            $display("FAIL lb_unsigned got %h err=%b want 0000008b/0", rd, err);
        end
        send(1'b0, 32'h12, 2'b01, 1'b0, 32'h0, vld, rd, err, erd, eerr);
        compared++;
        if (rd !== 32'hFFFF_8BAD || err !== 1'b0) begin
            mismatched++;
            $display("FAIL lh_signed got %h err=%b want ffff8bad/0", rd, err);
        end
    endtask

    task automatic test_strobe();
        logic vld, err, eerr;
        logic [31:0] rd, erd;
        send(1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344, vld, rd, err, erd, eerr);
        send(1'b1, 32'h21, 2'b00, 1'b0, 32'hABCDEF5A, vld, rd, err, erd, eerr);
        send(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, vld, rd, err, erd, eerr);
        compared++;
        if (rd !== 32'h1122_5A44 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL byte_strobe got %h err=%b want 11225a44/0", rd, err);
        end
    endtask

    task automatic test_errors();
        logic vld, err, eerr;
        logic [31:0] rd, erd;
        send(1'b1, 32'h0, 2'b10, 1'b0, 32'h01234567, vld, rd, err, erd, eerr);
        send(1'b0, 32'h400, 2'b10, 1'b0, 32'h0, vld, rd, err, erd, eerr);
        compared++;
        if (vld !== 1'b1 || rd !== 32'h0 || err !== 1'b1) begin
            mismatched++;
            $display("FAIL oob_load got vld=%b rdata=%h err=%b want 1/00000000/1", vld, rd, err);
        end
        send(1'b0, 32'h0, 2'b11, 1'b0, 32'h0, vld, rd, err, erd, eerr);
        compared++;
        if (rd !== 32'h0 || err !== 1'b1) begin
            mismatched++;
            $display("FAIL illegal_size got rdata=%h err=%b want 00000000/1", rd, err);
        end
        send(1'b1, 32'h400, 2'b10, 1'b0, 32'hDEADBEEF, vld, rd, err, erd, eerr);
        compared++;
        if (rd !== 32'h0 || err !== 1'b1) begin
            mismatched++;
            $display("FAIL oob_store got rdata=%h err=%b want 00000000/1", rd, err);
        end
        send(1'b0, 32'h0, 2'b10, 1'b0, 32'h0, vld, rd, err, erd, eerr);
        compared++;
        if (rd !== 32'h0123_4567 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL oob_store_no_alias got %h err=%b want 01234567/0", rd, err);
        end
    endtask

    task automatic test_hold();
        bit bad;
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b0;
        bus.req_addr     = 32'h20;
        bus.req_size     = SZ_WORD;
        bus.req_unsigned = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compared++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h1122_5A44 || bus.req_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL hold_cycle%0d got vld=%b rdata=%h rdy=%b want 1/11225a44/0",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        compared++;
        if (fsm_state !== ST_IDLE || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL hold_release got st=%0d rdy=%b vld=%b want %0d/1/0",
                     fsm_state, bus.req_ready, bus.rsp_valid, ST_IDLE);
        end
    endtask

    task automatic test_misalign();
        logic vld, err, eerr;
        logic [31:0] rd, erd;
        send(1'b1, 32'h10, 2'b10, 1'b0, 32'hCAFEBABE, vld, rd, err, erd, eerr);
        send(1'b0, 32'h11, 2'b10, 1'b0, 32'h0, vld, rd, err, erd, eerr);
        compared++;
`ifdef DMEM_MISALIGN_ERR_EN
        if (rd !== 32'h0 || err !== 1'b1) begin
            mismatched++;
            $display("FAIL misaligned_word got rdata=%h err=%b want 00000000/1", rd, err);
        end
`else
        if (rd !== 32'hCAFE_BABE || err !== 1'b0) begin
            mismatched++;
            $display("FAIL misaligned_word got rdata=%h err=%b want cafebabe/0", rd, err);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int n_rdy, n_vld;
        logic [31:0] erd;
        logic eerr;
        ref_access(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, erd, eerr);
        n_rdy = 0;
        n_vld = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h20;
        bus.req_size  = SZ_WORD;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bus.req_ready === 1'b1) n_rdy++;
            if (bus.rsp_valid === 1'b1) begin
                n_vld++;
                compared++;
                if (bus.rsp_rdata !== erd || bus.rsp_err !== eerr) begin
                    mismatched++;
                    $display("FAIL b2b_data got %h err=%b want %h/%b", bus.rsp_rdata, bus.rsp_err, erd, eerr);
                end
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        compared++;
        if (n_rdy != 4 || n_vld != 4) begin
            mismatched++;
            $display("FAIL b2b_rate got ready=%0d valid=%0d want 4/4 in 8 cycles", n_rdy, n_vld);
        end
    endtask

    task automatic test_random();
        logic vld, err, eerr, we, uns;
        logic [31:0] rd, erd, addr, wdata;
        logic [1:0] size;
        for (int i = 0; i < 200; i++) begin
            we    = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            wdata = $urandom;
            if ($urandom_range(0, 9) == 0) addr = 32'($urandom_range(32'h3F0, 32'h40F));
            else                           addr = 32'($urandom_range(0, 63));
            send(we, addr, size, uns, wdata, vld, rd, err, erd, eerr);
            compared++;
            if (vld !== 1'b1 || rd !== erd || err !== eerr) begin
                mismatched++;
                $display("FAIL random%0d we=%b a=%h sz=%0d u=%b got vld=%b rdata=%h err=%b want 1/%h/%b",
                         i, we, addr, size, uns, vld, rd, err, erd, eerr);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic vld, err, eerr;
        logic [31:0] rd, erd;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        compared++;
        if (bus.init_done !== 1'b0 || bus.req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset got done=%b rdy=%b want 0/0", bus.init_done, bus.req_ready);
        end
        release_and_count("first");
        // Let the sweep run partly, then abort it.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        compared++;
        if (bus.init_done !== 1'b0 || fsm_state !== ST_INIT) begin
            mismatched++;
            $display("FAIL mid_sweep_reset got done=%b st=%0d want 0/%0d", bus.init_done, fsm_state, ST_INIT);
        end
        release_and_count("restart");
        send(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, vld, rd, err, erd, eerr);
        compared++;
        if (rd !== INIT_VALUE || err !== 1'b0) begin
            mismatched++;
            $display("FAIL sweep_cleared got %h err=%b want %h/0", rd, err, INIT_VALUE);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        ref_clear();
        test_reset();
        test_top_word();
        test_extend();
        test_strobe();
        test_errors();
        test_hold();
        test_misalign();
        test_back_to_back();
        test_random();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised RV32 data memory with a valid/ready request channel and a valid/ready response channel. Supports byte, half and word loads and stores, with sign or zero extension and byte-lane write strobes. After reset, a hardware sweep clears the memory to a known value before the first request is accepted. Sits between the execute/memory stage and the load writeback path.

Parameters:
DEPTH, 256, number of 32-bit words; must be a power of two and at least 2.
ADDR_W, 32, byte-address width.
INIT_VALUE, 32'h0000_0000, word written to every location by the post-reset sweep.

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_we  in  1  1 = store, 0 = load.
req_addr  in  ADDR_W  byte address.
req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response.
rsp_rdata  out  32  extended load data; 0 for stores and errors.
rsp_err  out  1  access faulted.
init_done  out  1  high once the sweep has finished.

Behaviour:
- Reset state (asynchronous, rst_n low): state = INIT, sweep counter = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, init_done = 0.
- Reset asserted mid-operation aborts everything, including an in-progress sweep; the sweep restarts from index 0.
- States: INIT, IDLE, RESP.
- INIT:
  - Each cycle writes INIT_VALUE to mem[cnt] and increments cnt.
  - The cycle that writes index DEPTH-1 transitions to IDLE.
  - The sweep takes exactly DEPTH cycles. init_done rises with the IDLE entry and stays high until the next reset.
  - req_ready = 0 throughout INIT.
- IDLE:
  - req_ready = 1.
  - Handshake occurs when req_valid && req_ready. The block then moves to RESP.
  - rsp_valid = 1 from the next cycle; latency is 1 cycle.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready = 1.
  - The block returns to IDLE the cycle after that.
  - req_ready = 0 in RESP. Maximum throughput is one request per 2 cycles.
- Address decode:
  - Word index = req_addr[ADDR_W-1:2]; lane = req_addr[1:0].
  - Index >= DEPTH gives err.
  - req_size = 11 gives err.
  - Any error: no memory write, rsp_rdata = 0, rsp_err = 1.
- Store (performed on the handshake edge):
  - Byte: wdata[7:0] is written to lane addr[1:0].
  - Half: wdata[15:0] is written to lanes {addr[1],0} and {addr[1],1}.
  - Word: all 4 lanes are written.
  - Unwritten lanes keep their previous value.
  - Response: rsp_rdata = 0, rsp_err = 0.
- Load (memory read on the handshake edge, result registered):
  - Byte: select the lane, then extend bit 7 or zero-extend per req_unsigned.
  - Half: select the half by addr[1], then extend bit 15 or zero-extend.
  - Word: the raw word; req_unsigned is ignored.
- Misalignment (half with addr[0] = 1, or word with addr[1:0] != 0): handled per the optional feature below.
- Inputs other than req_valid are don't-care unless req_valid = 1.

Optional Feature:
Macro: DMEM_MISALIGN_ERR_EN.
- Defined: a misaligned access returns rsp_err = 1 and rsp_rdata = 0, and performs no write.
- Undefined: the offending low address bits are forced to 0 (access aligned down) and the access completes normally with rsp_err = 0.

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD and SZ_ILLEGAL;
  - the state enum ST_INIT, ST_IDLE, ST_RESP;
  - a function for byte-strobe generation;
  - a function for load extraction and extension.
- One sub-module, dmem_bank: a DEPTH x 32 synchronous RAM with a 4-bit byte write-enable and a registered read port. dmem_ctrl owns the FSM, the sweep counter and the decode.

Test Plan:
- Reset then idle: req_ready stays 0 for exactly 256 cycles; init_done rises with req_ready. A word load of address 0x3FC then returns 0x00000000, rsp_err = 0.
- Store word 0x8badf00d to 0x10, then load byte at 0x13 signed -> 0xFFFFFF8B. The same load unsigned -> 0x0000008B. Load half at 0x12 signed -> 0xFFFF8BAD.
- Store byte 0x5A to 0x21 over word 0x11223344 (stored at 0x20), then load word 0x20 -> 0x11225A44. This checks the strobes.
- Load word at 0x400 (index 256, beyond DEPTH) -> rsp_err = 1, rdata = 0. Illegal size 11 -> err. A store to 0x400 is ignored and the memory is unchanged.
- Hold rsp_ready = 0 for 5 cycles after a load: rsp_valid and rsp_rdata stay stable and req_ready stays 0. rsp_ready = 1 -> IDLE on the following cycle.
- Misaligned word load at 0x11, following a word store of 0xCAFEBABE to 0x10:
  - With DMEM_MISALIGN_ERR_EN: rsp_err = 1.
  - Without it: data 0xCAFEBABE, rsp_err = 0.
  - Assert rst_n low mid-sweep at cycle 100: init_done = 0 and the sweep restarts, completing 256 cycles after release.
